// File: rtl/div_iter_unit.sv
// Radix-2 restoring divider for DIV/DIVU with a start/ready handshake.
// One quotient bit per cycle on operand magnitudes; sign fixup on the final edge.
module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {FREE, BY_ZERO, ON, END} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic               signed_q;
    logic               dvd_neg_q;
    logic               dvs_neg_q;
    logic [WIDTH-1:0]   dvd_q;
    logic [WIDTH-1:0]   dvs_q;
    logic [WIDTH-1:0]   rem_q;
    logic [2*WIDTH-1:0] result_q;
    logic               ready_q;

    logic               dvd_neg;
    logic               dvs_neg;
    logic [WIDTH-1:0]   dvd_mag;
    logic [WIDTH-1:0]   dvs_mag;
    logic [WIDTH:0]     rem_sh;
    logic [WIDTH:0]     diff;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   dvd_d;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign dvd_neg = signed_div_i & opdata1_i[WIDTH-1];
    assign dvs_neg = signed_div_i & opdata2_i[WIDTH-1];
    assign dvd_mag = dvd_neg ? -opdata1_i : opdata1_i;
    assign dvs_mag = dvs_neg ? -opdata2_i : opdata2_i;

    // dvd_q doubles as the quotient shift register: dividend bits leave at
    // the top while quotient bits enter at the bottom.
    assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};
    assign rem_d  = diff[WIDTH] ? rem_sh[WIDTH-1:0] : diff[WIDTH-1:0];
    assign dvd_d  = {dvd_q[WIDTH-2:0], ~diff[WIDTH]};

    assign quo_fix = (signed_q & (dvd_neg_q ^ dvs_neg_q)) ? -dvd_q : dvd_q;
    assign rem_fix = (signed_q & dvd_neg_q) ? -rem_q : rem_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            signed_q  <= 1'b0;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    if (!annul_i && start_i) begin
                        signed_q  <= signed_div_i;
                        dvd_neg_q <= dvd_neg;
                        dvs_neg_q <= dvs_neg;
                        dvd_q     <= dvd_mag;
                        dvs_q     <= dvs_mag;
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= (dvs_mag == '0) ? BY_ZERO : ON;
                    end
                end
                BY_ZERO: begin
                    result_q <= '0;
                    ready_q  <= 1'b1;
                    state_q  <= END;
                end
                ON: begin
                    if (annul_i) begin
                        result_q <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= FREE;
                    end else if (cnt_q == CW'(WIDTH)) begin
                        result_q <= {rem_fix, quo_fix};
                        ready_q  <= 1'b1;
                        state_q  <= END;
                    end else begin
                        rem_q <= rem_d;
                        dvd_q <= dvd_d;
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                END: begin
                    if (!start_i) begin
                        result_q <= '0;
                        ready_q  <= 1'b0;
                        state_q  <= FREE;
                    end
                end
                default: state_q <= FREE;
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule
